// File: rtl/axi_pkg.sv
// AXI4 bus widths, burst/response encodings and the request/response
// channel bundles shared by masters and responders on the DMA fabric.
package axi_pkg;

  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_DATA_WIDTH = 512;
  localparam int AXI_ID_WIDTH   = 4;
  localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // Master-driven channels: AW, W, B-ready, AR, R-ready
  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0]   aw_id;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;
    logic                      aw_valid;
    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [AXI_STRB_WIDTH-1:0] w_strb;
    logic                      w_last;
    logic                      w_valid;
    logic                      b_ready;
    logic [AXI_ID_WIDTH-1:0]   ar_id;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;
    logic                      ar_valid;
    logic                      r_ready;
  } axi_req_t;

  // Responder-driven channels: AW/W-ready, B, AR-ready, R
  typedef struct packed {
    logic                      aw_ready;
    logic                      w_ready;
    logic [AXI_ID_WIDTH-1:0]   b_id;
    logic [1:0]                b_resp;
    logic                      b_valid;
    logic                      ar_ready;
    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0]                r_resp;
    logic                      r_last;
    logic                      r_valid;
  } axi_resp_t;

endpackage

// File: rtl/dma_pkg.sv
// Shared definitions for the DMA AXI memory responder: FSM state encodings,
// word geometry, stall-LFSR constants and the per-beat address helpers.
package dma_pkg;

  import axi_pkg::*;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } dma_slv_wstate_e;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_DATA  = 2'd2
  } dma_slv_rstate_e;

  localparam int DMA_SLV_BYTES_PER_WORD = AXI_DATA_WIDTH / 8;
  localparam int DMA_SLV_WORD_LSB       = $clog2(DMA_SLV_BYTES_PER_WORD);
  localparam logic [2:0] DMA_SLV_SIZE_MAX = 3'(DMA_SLV_WORD_LSB);

  // Fibonacci LFSR, taps 16,14,13,11 -> bit positions 15,13,12,10
  localparam logic [15:0] DMA_SLV_LFSR_SEED = 16'hACE1;
  localparam logic [15:0] DMA_SLV_LFSR_TAPS = 16'hB400;

  // A beat errors when it falls outside the array, uses a size wider than
  // the bus, or asks for a WRAP burst (not supported by this responder).
  function automatic logic dma_slv_beat_err(
    input logic [AXI_ADDR_WIDTH-1:0] addr,
    input logic [AXI_ADDR_WIDTH-1:0] base,
    input logic [63:0]               mem_bytes,
    input logic [2:0]                size,
    input logic [1:0]                burst
  );
    logic [AXI_ADDR_WIDTH-1:0] off;
    off = addr - base;
    return (64'(off) >= mem_bytes) || (size > DMA_SLV_SIZE_MAX) ||
           (burst == AXI_BURST_WRAP);
  endfunction

  // INCR: align down to the beat size, then step by one beat (wraps mod 2^N).
  // FIXED: the address never moves.
  function automatic logic [AXI_ADDR_WIDTH-1:0] dma_slv_next_addr(
    input logic [AXI_ADDR_WIDTH-1:0] addr,
    input logic [2:0]                size,
    input logic [1:0]                burst
  );
    logic [AXI_ADDR_WIDTH-1:0] step;
    step = AXI_ADDR_WIDTH'(1) << size;
    if (burst == AXI_BURST_FIXED) begin
      return addr;
    end
    return (addr & ~(step - AXI_ADDR_WIDTH'(1))) + step;
  endfunction

endpackage

// File: rtl/dma_slv_ram.sv
// 1R1W word array with per-byte write strobes and a registered read port.
// A read and a write to the same word in one cycle return the old contents.
module dma_slv_ram #(
  parameter int DEPTH = 1024,
  parameter int DW    = 512,
  localparam int AW   = $clog2(DEPTH),
  localparam int BW   = DW / 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [BW-1:0] i_wstrb,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  // Byte-enabled write and registered read; non-blocking order gives read-first
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < BW; b++) begin
        if (i_wstrb[b]) begin
          r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dma_axi_mem_slave.sv
// AXI4 responder memory model: independent read and write burst FSMs in
// front of a byte-strobed 1R1W array. Define DMA_AXI_SLV_STALL_EN to add
// LFSR-driven ready throttling and response delays for stress testing.
module dma_axi_mem_slave
  import axi_pkg::*;
  import dma_pkg::*;
#(
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int                        MEM_DEPTH = 1024
) (
  input  logic      clk,
  input  logic      rst,
  input  axi_req_t  axi_req_i,
  output axi_resp_t axi_resp_o
);

  localparam int         WORD_AW   = $clog2(MEM_DEPTH);
  localparam logic [63:0] MEM_BYTES = 64'(MEM_DEPTH) * 64'(DMA_SLV_BYTES_PER_WORD);

  // Stall controls: w_hs_en gates the address/data readies, w_adv_en gates
  // the transitions that raise bvalid/rvalid.
  logic w_hs_en;
  logic w_adv_en;

`ifdef DMA_AXI_SLV_STALL_EN
  logic [15:0] r_lfsr;

  // Free-running LFSR supplying the pseudo-random stall decisions
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= DMA_SLV_LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & DMA_SLV_LFSR_TAPS)};
    end
  end

  assign w_hs_en  = r_lfsr[0];
  assign w_adv_en = r_lfsr[1];
`else
  assign w_hs_en  = 1'b1;
  assign w_adv_en = 1'b1;
`endif

  // ---------------- write side ----------------
  dma_slv_wstate_e           r_wstate;
  logic                      r_awready;
  logic                      r_wready;
  logic                      r_bvalid;
  logic [AXI_ID_WIDTH-1:0]   r_bid;
  logic [1:0]                r_bresp;
  logic [AXI_ID_WIDTH-1:0]   r_wid;
  logic [AXI_ADDR_WIDTH-1:0] r_waddr;
  logic [7:0]                r_wlen;
  logic [2:0]                r_wsize;
  logic [1:0]                r_wburst;
  logic [7:0]                r_wbeat;
  logic                      r_werr;
  logic                      r_wdone;

  logic                      w_aw_hs;
  logic                      w_w_hs;
  logic                      w_w_last;
  logic                      w_w_err;
  logic                      w_ram_we;
  logic [WORD_AW-1:0]        w_waddr_idx;

  assign w_aw_hs     = axi_req_i.aw_valid & r_awready & w_hs_en;
  assign w_w_hs      = axi_req_i.w_valid & r_wready & w_hs_en;
  assign w_w_last    = (r_wbeat == r_wlen);
  assign w_w_err     = dma_slv_beat_err(r_waddr, BASE_ADDR, MEM_BYTES, r_wsize, r_wburst) |
                       (axi_req_i.w_last != w_w_last);
  assign w_ram_we    = w_w_hs & ~w_w_err;
  assign w_waddr_idx = WORD_AW'((r_waddr - BASE_ADDR) >> DMA_SLV_WORD_LSB);

  // Write burst FSM: AW capture, per-beat strobed writes, B response
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bid     <= '0;
      r_bresp   <= AXI_RESP_OKAY;
      r_wid     <= '0;
      r_waddr   <= '0;
      r_wlen    <= '0;
      r_wsize   <= '0;
      r_wburst  <= '0;
      r_wbeat   <= '0;
      r_werr    <= 1'b0;
      r_wdone   <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          r_awready <= 1'b1;
          if (w_aw_hs) begin
            r_wid     <= axi_req_i.aw_id;
            r_waddr   <= axi_req_i.aw_addr;
            r_wlen    <= axi_req_i.aw_len;
            r_wsize   <= axi_req_i.aw_size;
            r_wburst  <= axi_req_i.aw_burst;
            r_wbeat   <= '0;
            r_werr    <= 1'b0;
            r_wdone   <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_wstate  <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_w_hs) begin
            r_werr <= r_werr | w_w_err;
            if (w_w_last) begin
              r_wready <= 1'b0;
              if (w_adv_en) begin
                r_bvalid <= 1'b1;
                r_bid    <= r_wid;
                r_bresp  <= (r_werr | w_w_err) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                r_wstate <= W_RESP;
              end else begin
                r_wdone <= 1'b1;
              end
            end else begin
              r_wbeat <= r_wbeat + 8'd1;
              r_waddr <= dma_slv_next_addr(r_waddr, r_wsize, r_wburst);
            end
          end else if (r_wdone && w_adv_en) begin
            r_bvalid <= 1'b1;
            r_bid    <= r_wid;
            r_bresp  <= r_werr ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            r_wstate <= W_RESP;
          end
        end
        W_RESP: begin
          if (axi_req_i.b_ready) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // ---------------- read side ----------------
  dma_slv_rstate_e           r_rstate;
  logic                      r_arready;
  logic                      r_rvalid;
  logic [AXI_ID_WIDTH-1:0]   r_rid;
  logic [1:0]                r_rresp;
  logic                      r_rlast;
  logic                      r_rerr;
  logic [AXI_ID_WIDTH-1:0]   r_arid;
  logic [AXI_ADDR_WIDTH-1:0] r_raddr;
  logic [7:0]                r_rlen;
  logic [2:0]                r_rsize;
  logic [1:0]                r_rburst;
  logic [7:0]                r_rbeat;

  logic                      w_ar_hs;
  logic                      w_r_hs;
  logic                      w_r_err;
  logic                      w_ram_re;
  logic [WORD_AW-1:0]        w_raddr_idx;
  logic [AXI_DATA_WIDTH-1:0] w_ram_rdata;

  assign w_ar_hs     = axi_req_i.ar_valid & r_arready & w_hs_en;
  assign w_r_hs      = r_rvalid & axi_req_i.r_ready;
  assign w_r_err     = dma_slv_beat_err(r_raddr, BASE_ADDR, MEM_BYTES, r_rsize, r_rburst);
  assign w_ram_re    = (r_rstate == R_FETCH);
  assign w_raddr_idx = WORD_AW'((r_raddr - BASE_ADDR) >> DMA_SLV_WORD_LSB);

  // Read burst FSM: AR capture, one fetch cycle per beat, R beat held until taken
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rid     <= '0;
      r_rresp   <= AXI_RESP_OKAY;
      r_rlast   <= 1'b0;
      r_rerr    <= 1'b0;
      r_arid    <= '0;
      r_raddr   <= '0;
      r_rlen    <= '0;
      r_rsize   <= '0;
      r_rburst  <= '0;
      r_rbeat   <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          r_arready <= 1'b1;
          if (w_ar_hs) begin
            r_arid    <= axi_req_i.ar_id;
            r_raddr   <= axi_req_i.ar_addr;
            r_rlen    <= axi_req_i.ar_len;
            r_rsize   <= axi_req_i.ar_size;
            r_rburst  <= axi_req_i.ar_burst;
            r_rbeat   <= '0;
            r_arready <= 1'b0;
            r_rstate  <= R_FETCH;
          end
        end
        R_FETCH: begin
          if (w_adv_en) begin
            r_rvalid <= 1'b1;
            r_rid    <= r_arid;
            r_rlast  <= (r_rbeat == r_rlen);
            r_rerr   <= w_r_err;
            r_rresp  <= w_r_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            r_rstate <= R_DATA;
          end
        end
        R_DATA: begin
          if (w_r_hs) begin
            r_rvalid <= 1'b0;
            if (r_rlast) begin
              r_rlast   <= 1'b0;
              r_arready <= 1'b1;
              r_rstate  <= R_IDLE;
            end else begin
              r_rbeat  <= r_rbeat + 8'd1;
              r_raddr  <= dma_slv_next_addr(r_raddr, r_rsize, r_rburst);
              r_rstate <= R_FETCH;
            end
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  dma_slv_ram #(
    .DEPTH (MEM_DEPTH),
    .DW    (AXI_DATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_waddr (w_waddr_idx),
    .i_wdata (axi_req_i.w_data),
    .i_wstrb (axi_req_i.w_strb),
    .i_re    (w_ram_re),
    .i_raddr (w_raddr_idx),
    .o_rdata (w_ram_rdata)
  );

  // Response bundle; rdata is forced to zero outside a valid, error-free beat
  always_comb begin
    axi_resp_o          = '0;
    axi_resp_o.aw_ready = r_awready & w_hs_en;
    axi_resp_o.w_ready  = r_wready & w_hs_en;
    axi_resp_o.b_valid  = r_bvalid;
    axi_resp_o.b_id     = r_bid;
    axi_resp_o.b_resp   = r_bresp;
    axi_resp_o.ar_ready = r_arready & w_hs_en;
    axi_resp_o.r_valid  = r_rvalid;
    axi_resp_o.r_id     = r_rid;
    axi_resp_o.r_resp   = r_rresp;
    axi_resp_o.r_last   = r_rlast;
    axi_resp_o.r_data   = (r_rvalid && !r_rerr) ? w_ram_rdata : '0;
  end

endmodule

// File: tb/tb_dma_axi_mem_slave.sv
// Directed bench for the AXI memory responder: bursts, strobes, range
// errors, backpressure, early wlast, concurrent AW/AR and mid-burst reset.
module tb_dma_axi_mem_slave;
  import axi_pkg::*;

  logic      clk;
  logic      rst;
  axi_req_t  req;
  axi_resp_t resp;

  int n_checks;
  int n_errors;

  logic [511:0] wd     [4];
  logic [511:0] rd_exp [4];
  logic [1:0]   rr_exp [4];

  dma_axi_mem_slave dut (
    .clk        (clk),
    .rst        (rst),
    .axi_req_i  (req),
    .axi_resp_o (resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id, input logic [63:0] strb,
                           input logic [3:0] last_mask, input int bdelay,
                           input logic [1:0] exp_bresp, input string tag);
    int n;
    req.aw_addr  = addr;
    req.aw_len   = len;
    req.aw_size  = size;
    req.aw_burst = burst;
    req.aw_id    = id;
    req.aw_valid = 1'b1;
    n = 0;
    while (resp.aw_ready !== 1'b1 && n < 50) begin tick(); n++; end
    chk({tag, "_aw_timeout"}, n < 50, 1);
    tick();
    req.aw_valid = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      req.w_data  = wd[k];
      req.w_strb  = strb;
      req.w_last  = last_mask[k];
      req.w_valid = 1'b1;
      n = 0;
      while (resp.w_ready !== 1'b1 && n < 50) begin tick(); n++; end
      chk({tag, "_w_timeout"}, n < 50, 1);
      tick();
    end
    req.w_valid = 1'b0;
    req.w_last  = 1'b0;
    chk({tag, "_bvalid_lat"}, resp.b_valid, 1);
    for (int c = 0; c < bdelay; c++) begin
      tick();
      chk({tag, "_bvalid_hold"}, resp.b_valid, 1);
    end
    chk({tag, "_bresp"}, resp.b_resp, exp_bresp);
    chk({tag, "_bid"}, resp.b_id, id);
    req.b_ready = 1'b1;
    tick();
    req.b_ready = 1'b0;
    chk({tag, "_bvalid_drop"}, resp.b_valid, 0);
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id,
                          input int stall_beat, input int stall_cyc, input string tag);
    int n;
    req.ar_addr  = addr;
    req.ar_len   = len;
    req.ar_size  = size;
    req.ar_burst = burst;
    req.ar_id    = id;
    req.ar_valid = 1'b1;
    n = 0;
    while (resp.ar_ready !== 1'b1 && n < 50) begin tick(); n++; end
    chk({tag, "_ar_timeout"}, n < 50, 1);
    tick();
    req.ar_valid = 1'b0;
    chk({tag, "_rvalid_lat1"}, resp.r_valid, 0);
    tick();
    chk({tag, "_rvalid_lat2"}, resp.r_valid, 1);
    for (int k = 0; k <= int'(len); k++) begin
      n = 0;
      while (resp.r_valid !== 1'b1 && n < 50) begin tick(); n++; end
      chk({tag, "_r_timeout"}, n < 50, 1);
      chk({tag, "_rdata"}, resp.r_data, rd_exp[k]);
      chk({tag, "_rresp"}, resp.r_resp, rr_exp[k]);
      chk({tag, "_rlast"}, resp.r_last, (k == int'(len)) ? 1 : 0);
      chk({tag, "_rid"}, resp.r_id, id);
      if (k == stall_beat) begin
        for (int c = 0; c < stall_cyc; c++) begin
          tick();
          chk({tag, "_hold_rvalid"}, resp.r_valid, 1);
          chk({tag, "_hold_rdata"}, resp.r_data, rd_exp[k]);
          chk({tag, "_hold_rresp"}, resp.r_resp, rr_exp[k]);
          chk({tag, "_hold_rlast"}, resp.r_last, (k == int'(len)) ? 1 : 0);
        end
      end
      req.r_ready = 1'b1;
      tick();
      req.r_ready = 1'b0;
    end
    chk({tag, "_rvalid_end"}, resp.r_valid, 0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    req = '0;
    rst = 1'b1;
    repeat (3) tick();

    // reset state
    chk("rst_resp_zero", (resp === '0) ? 1 : 0, 1);
    rst = 1'b0;
    tick();
    chk("post_rst_awready", resp.aw_ready, 1);
    chk("post_rst_arready", resp.ar_ready, 1);

    // INCR 4-beat write with bready held off 3 cycles, then read back with
    // rready held off 5 cycles on beat 1
    wd[0] = {64{8'h00}};
    wd[1] = {64{8'h11}};
    wd[2] = {64{8'h22}};
    wd[3] = {64{8'h33}};
    axi_write(32'h100, 8'd3, 3'd6, AXI_BURST_INCR, 4'h3, {64{1'b1}}, 4'b1000, 3,
              AXI_RESP_OKAY, "incr_wr");
    rd_exp = wd;
    rr_exp = '{AXI_RESP_OKAY, AXI_RESP_OKAY, AXI_RESP_OKAY, AXI_RESP_OKAY};
    axi_read(32'h100, 8'd3, 3'd6, AXI_BURST_INCR, 4'h9, 1, 5, "incr_rd");

    // partial strobe: only bytes 0-3 replaced
    wd[0] = {64{8'hAA}};
    axi_write(32'h40, 8'd0, 3'd6, AXI_BURST_INCR, 4'h1, {64{1'b1}}, 4'b0001, 0,
              AXI_RESP_OKAY, "strb_fill");
    wd[0] = {64{8'h55}};
    axi_write(32'h40, 8'd0, 3'd6, AXI_BURST_INCR, 4'h2, 64'h0F, 4'b0001, 0,
              AXI_RESP_OKAY, "strb_part");
    rd_exp[0] = {{60{8'hAA}}, {4{8'h55}}};
    rr_exp[0] = AXI_RESP_OKAY;
    axi_read(32'h40, 8'd0, 3'd6, AXI_BURST_INCR, 4'h2, -1, 0, "strb_rd");

    // out of range: read gives zero data + SLVERR, write is dropped
    rd_exp[0] = '0;
    rd_exp[1] = '0;
    rr_exp[0] = AXI_RESP_SLVERR;
    rr_exp[1] = AXI_RESP_SLVERR;
    axi_read(32'h10000, 8'd1, 3'd6, AXI_BURST_INCR, 4'h4, -1, 0, "oor_rd");
    wd[0] = {64{8'h5A}};
    axi_write(32'h0, 8'd0, 3'd6, AXI_BURST_INCR, 4'h5, {64{1'b1}}, 4'b0001, 0,
              AXI_RESP_OKAY, "oor_pre");
    wd[0] = {64{8'hFF}};
    axi_write(32'h10000, 8'd0, 3'd6, AXI_BURST_INCR, 4'h6, {64{1'b1}}, 4'b0001, 0,
              AXI_RESP_SLVERR, "oor_wr");
    rd_exp[0] = {64{8'h5A}};
    rr_exp[0] = AXI_RESP_OKAY;
    axi_read(32'h0, 8'd0, 3'd6, AXI_BURST_INCR, 4'h5, -1, 0, "oor_chk");

    // oversize beat on read
    rd_exp[0] = '0;
    rr_exp[0] = AXI_RESP_SLVERR;
    axi_read(32'h100, 8'd0, 3'd7, AXI_BURST_INCR, 4'h7, -1, 0, "size_rd");

    // early wlast: beat 1 is flagged and not written, beat 0 lands
    wd[0] = {64{8'h77}};
    axi_write(32'h240, 8'd0, 3'd6, AXI_BURST_INCR, 4'h1, {64{1'b1}}, 4'b0001, 0,
              AXI_RESP_OKAY, "wl_pre");
    wd[0] = {64{8'h21}};
    wd[1] = {64{8'h22}};
    wd[2] = {64{8'h23}};
    wd[3] = {64{8'h24}};
    axi_write(32'h200, 8'd3, 3'd6, AXI_BURST_INCR, 4'h8, {64{1'b1}}, 4'b0010, 0,
              AXI_RESP_SLVERR, "wl_early");
    rd_exp[0] = {64{8'h21}};
    rd_exp[1] = {64{8'h77}};
    rr_exp[0] = AXI_RESP_OKAY;
    rr_exp[1] = AXI_RESP_OKAY;
    axi_read(32'h200, 8'd1, 3'd6, AXI_BURST_INCR, 4'h8, -1, 0, "wl_rd");

    // FIXED burst: both beats hit the same word, last one wins
    wd[0] = {64{8'h01}};
    wd[1] = {64{8'h02}};
    axi_write(32'h300, 8'd1, 3'd6, AXI_BURST_FIXED, 4'hA, {64{1'b1}}, 4'b0010, 0,
              AXI_RESP_OKAY, "fix_wr");
    rd_exp[0] = {64{8'h02}};
    rd_exp[1] = {64{8'h02}};
    axi_read(32'h300, 8'd1, 3'd6, AXI_BURST_FIXED, 4'hA, -1, 0, "fix_rd");

    // concurrent AW + AR to word 0x140 (holds 0x11s): read sees old data
    req.aw_addr  = 32'h140;
    req.aw_len   = 8'd0;
    req.aw_size  = 3'd6;
    req.aw_burst = AXI_BURST_INCR;
    req.aw_id    = 4'h5;
    req.aw_valid = 1'b1;
    req.ar_addr  = 32'h140;
    req.ar_len   = 8'd0;
    req.ar_size  = 3'd6;
    req.ar_burst = AXI_BURST_INCR;
    req.ar_id    = 4'h6;
    req.ar_valid = 1'b1;
    req.w_data   = {64{8'hEE}};
    req.w_strb   = {64{1'b1}};
    req.w_last   = 1'b1;
    req.w_valid  = 1'b1;
    chk("cc_awready", resp.aw_ready, 1);
    chk("cc_arready", resp.ar_ready, 1);
    tick();
    req.aw_valid = 1'b0;
    req.ar_valid = 1'b0;
    chk("cc_aw_taken", resp.aw_ready, 0);
    chk("cc_ar_taken", resp.ar_ready, 0);
    chk("cc_wready", resp.w_ready, 1);
    tick();
    req.w_valid = 1'b0;
    req.w_last  = 1'b0;
    chk("cc_rvalid", resp.r_valid, 1);
    chk("cc_rdata_old", resp.r_data, {64{8'h11}});
    chk("cc_bvalid", resp.b_valid, 1);
    chk("cc_bresp", resp.b_resp, AXI_RESP_OKAY);
    req.r_ready = 1'b1;
    req.b_ready = 1'b1;
    tick();
    req.r_ready = 1'b0;
    req.b_ready = 1'b0;
    chk("cc_rvalid_drop", resp.r_valid, 0);
    chk("cc_bvalid_drop", resp.b_valid, 0);
    rd_exp[0] = {64{8'hEE}};
    rr_exp[0] = AXI_RESP_OKAY;
    axi_read(32'h140, 8'd0, 3'd6, AXI_BURST_INCR, 4'h6, -1, 0, "cc_new");

    // reset pulsed mid-read burst
    req.ar_addr  = 32'h100;
    req.ar_len   = 8'd3;
    req.ar_size  = 3'd6;
    req.ar_burst = AXI_BURST_INCR;
    req.ar_id    = 4'h2;
    req.ar_valid = 1'b1;
    chk("mr_arready", resp.ar_ready, 1);
    tick();
    req.ar_valid = 1'b0;
    tick();
    chk("mr_rvalid_before", resp.r_valid, 1);
    rst = 1'b1;
    tick();
    chk("mr_rvalid_rst", resp.r_valid, 0);
    chk("mr_arready_rst", resp.ar_ready, 0);
    chk("mr_rdata_rst", resp.r_data, 0);
    rst = 1'b0;
    tick();
    chk("mr_arready_rel", resp.ar_ready, 1);
    chk("mr_rvalid_rel", resp.r_valid, 0);
    axi_read(32'h140, 8'd0, 3'd6, AXI_BURST_INCR, 4'h3, -1, 0, "mr_after");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
